// File: rtl/fmul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fmul_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fcls_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fflags_t;

  // Control payload that travels with the product from S2 into S3.
  typedef struct packed {
    logic  sign;
    logic  rnd;
    fcls_e cls_a;
    fcls_e cls_b;
  } s2_ctrl_t;

  function automatic int unsigned bias(input int unsigned ew);
    return (32'd1 << (ew - 32'd1)) - 32'd1;
  endfunction

  // Quiet NaN {exp, frac} image right-aligned in a 64-bit word; callers slice it.
  function automatic logic [63:0] qnan(input int unsigned ew, input int unsigned fw);
    logic [63:0] r;
    r = ((64'd1 << ew) - 64'd1) << fw;
    r = r | (64'd1 << (fw - 32'd1));
    return r;
  endfunction

  // Denormals are flushed: any zero exponent classifies as zero.
  function automatic fcls_e classify(input logic exp_zero, input logic exp_max,
                                     input logic frac_nz);
    if (exp_zero)     return CLS_ZERO;
    else if (!exp_max) return CLS_NORM;
    else if (frac_nz)  return CLS_NAN;
    else               return CLS_INF;
  endfunction

endpackage

// File: rtl/fmul_mant_mult.sv
// Unsigned mantissa multiplier; kept separate so a tree multiplier can replace it.
module fmul_mant_mult #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage floating-point multiplier: S1 operands/classify, S2 product/exponent,
// S3 normalise/round/pack into the output registers. Whole pipe advances together.
module fmul_pipe
  import fmul_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rnd_mode,
  input  logic              a_sign,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [FRAC_W-1:0] a_frac,
  input  logic              b_sign,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic [FRAC_W-1:0] b_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac,
  output logic              invalid,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  localparam int unsigned MW = FRAC_W + 1;
  localparam int unsigned PW = 2 * MW;
  localparam int unsigned EW = EXP_W + 2;

  localparam logic [EXP_W-1:0] EMAX    = '1;
  localparam logic [EW-1:0]    EMAX_E  = {2'b00, EMAX};
  localparam int unsigned      BIAS    = bias(EXP_W);
  localparam logic [EW-1:0]    BIAS_E  = EW'(BIAS);
  localparam logic [63:0]      QNAN_W  = qnan(EXP_W, FRAC_W);
  localparam logic [EXP_W+FRAC_W-1:0] QNAN = QNAN_W[EXP_W+FRAC_W-1:0];

  logic adv;

  // S1 registers
  logic              v1_q;
  logic              rnd1_q;
  logic              a_sign_q, b_sign_q;
  logic [EXP_W-1:0]  a_exp_q, b_exp_q;
  logic [FRAC_W-1:0] a_frac_q, b_frac_q;

  // S2 registers
  logic              v2_q;
  logic [PW-1:0]     p_q;
  logic [EW-1:0]     e2_q;
  s2_ctrl_t          ctrl2_q;

  // S3 / output registers
  logic              v3_q;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  fflags_t           flags_q, flags_d;

  // S1 combinational
  fcls_e             cls_a, cls_b;
  logic [PW-1:0]     prod;
  logic [EW-1:0]     e1;
  s2_ctrl_t          ctrl1;

  // S3 combinational
  logic              n;
  logic [PW-2:0]     sh;
  logic [FRAC_W-1:0] mant, mant_r;
  logic              g, s, up, carry;
  logic [EW-1:0]     e_r;
  logic              ovf, unf;

  assign adv      = ~v3_q | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      rnd1_q   <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      a_exp_q  <= '0;
      b_exp_q  <= '0;
      a_frac_q <= '0;
      b_frac_q <= '0;
    end else if (adv) begin
      v1_q     <= in_valid;
      rnd1_q   <= rnd_mode;
      a_sign_q <= a_sign;
      b_sign_q <= b_sign;
      a_exp_q  <= a_exp;
      b_exp_q  <= b_exp;
      a_frac_q <= a_frac;
      b_frac_q <= b_frac;
    end
  end

  assign cls_a = classify(a_exp_q == '0, a_exp_q == EMAX, |a_frac_q);
  assign cls_b = classify(b_exp_q == '0, b_exp_q == EMAX, |b_frac_q);

  fmul_mant_mult #(
    .W(MW)
  ) u_mult (
    .a_i({1'b1, a_frac_q}),
    .b_i({1'b1, b_frac_q}),
    .p_o(prod)
  );

  assign e1    = {2'b00, a_exp_q} + {2'b00, b_exp_q} - BIAS_E;
  assign ctrl1 = '{sign: a_sign_q ^ b_sign_q, rnd: rnd1_q, cls_a: cls_a, cls_b: cls_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      p_q     <= '0;
      e2_q    <= '0;
      ctrl2_q <= '{sign: 1'b0, rnd: 1'b0, cls_a: CLS_ZERO, cls_b: CLS_ZERO};
    end else if (adv) begin
      v2_q    <= v1_q;
      p_q     <= prod;
      e2_q    <= e1;
      ctrl2_q <= ctrl1;
    end
  end

  // Left-align the product so the leading 1 always sits just above sh[PW-2];
  // the shifted-in zero never contributes to sticky.
  assign n    = p_q[PW-1];
  assign sh   = n ? p_q[PW-2:0] : {p_q[PW-3:0], 1'b0};
  assign mant = sh[PW-2 -: FRAC_W];
  assign g    = sh[FRAC_W];
  assign s    = |sh[FRAC_W-1:0];
  assign up   = ~ctrl2_q.rnd & g & (s | mant[0]);

  assign {carry, mant_r} = {1'b0, mant} + {{FRAC_W{1'b0}}, up};
  assign e_r = e2_q + {{(EW-1){1'b0}}, n} + {{(EW-1){1'b0}}, carry};
  assign ovf = ~e_r[EW-1] & (e_r >= EMAX_E);
  assign unf = e_r[EW-1] | (e_r == '0);

  always_comb begin
    sign_d  = ctrl2_q.sign;
    exp_d   = e_r[EXP_W-1:0];
    frac_d  = mant_r;
    flags_d = '0;
    if (ctrl2_q.cls_a == CLS_NAN || ctrl2_q.cls_b == CLS_NAN ||
        (ctrl2_q.cls_a == CLS_INF && ctrl2_q.cls_b == CLS_ZERO) ||
        (ctrl2_q.cls_a == CLS_ZERO && ctrl2_q.cls_b == CLS_INF)) begin
      sign_d          = 1'b0;
      {exp_d, frac_d} = QNAN;
      flags_d.invalid = 1'b1;
    end else if (ctrl2_q.cls_a == CLS_INF || ctrl2_q.cls_b == CLS_INF) begin
      exp_d  = EMAX;
      frac_d = '0;
    end else if (ctrl2_q.cls_a == CLS_ZERO || ctrl2_q.cls_b == CLS_ZERO) begin
      exp_d  = '0;
      frac_d = '0;
    end else if (ovf) begin
      flags_d.overflow = 1'b1;
      flags_d.inexact  = 1'b1;
      if (ctrl2_q.rnd) begin
        exp_d  = {{(EXP_W-1){1'b1}}, 1'b0};
        frac_d = '1;
      end else begin
        exp_d  = EMAX;
        frac_d = '0;
      end
    end else if (unf) begin
      exp_d             = '0;
      frac_d            = '0;
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
    end else begin
      flags_d.inexact = g | s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q    <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      frac_q  <= '0;
      flags_q <= '0;
    end else if (adv) begin
      v3_q    <= v2_q;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      frac_q  <= frac_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = v3_q;
  assign sign      = sign_q;
  assign exp       = exp_q;
  assign frac      = frac_q;
  assign invalid   = flags_q.invalid;
  assign overflow  = flags_q.overflow;
  assign underflow = flags_q.underflow;
  assign inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe (FP32): scoreboard against an arithmetic reference model,
// plus directed corner cases, backpressure and mid-flight reset.
module tb_fmul_pipe;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        rnd_mode = 1'b0;
  logic        a_sign = 1'b0, b_sign = 1'b0;
  logic [7:0]  a_exp = '0, b_exp = '0;
  logic [22:0] a_frac = '0, b_frac = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign;
  logic [7:0]  exp;
  logic [22:0] frac;
  logic        invalid, overflow, underflow, inexact;

  int tests = 0;
  int fails = 0;
  int n_out = 0;
  logic [35:0] q[$];

  fmul_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rnd_mode(rnd_mode), .a_sign(a_sign), .a_exp(a_exp), .a_frac(a_frac),
    .b_sign(b_sign), .b_exp(b_exp), .b_frac(b_frac),
    .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .exp(exp),
    .frac(frac), .invalid(invalid), .overflow(overflow),
    .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] dut_word();
    return {invalid, overflow, underflow, inexact, sign, exp, frac};
  endfunction

  // Reference: exact integer product, rounded by comparing the remainder with one half.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic rnd);
    logic sa, sb, s;
    int ea, eb, e, shift;
    longint unsigned ma, mb, p, qv, rem, half;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    sa = a[31]; sb = b[31]; s = sa ^ sb;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return {4'b1000, 32'h7FC00000};
    if ((a_inf && b_zero) || (a_zero && b_inf)) return {4'b1000, 32'h7FC00000};
    if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {4'b0000, s, 31'h0};
    ma = 64'h800000 | 64'(a[22:0]);
    mb = 64'h800000 | 64'(b[22:0]);
    p = ma * mb;
    shift = (p >= (64'd1 << 47)) ? 24 : 23;
    e = ea + eb - 127 + (shift - 23);
    qv = p >> shift;
    rem = p & ((64'd1 << shift) - 64'd1);
    half = 64'd1 << (shift - 1);
    if (!rnd && (rem > half || (rem == half && qv[0]))) qv = qv + 64'd1;
    if (qv == (64'd1 << 24)) begin
      qv = qv >> 1;
      e = e + 1;
    end
    if (e >= 255) return rnd ? {4'b0101, s, 8'hFE, 23'h7FFFFF} : {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, rem != 0, s, e[7:0], qv[22:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic r);
    {a_sign, a_exp, a_frac} = a;
    {b_sign, b_exp, b_frac} = b;
    rnd_mode = r;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3, 4: v[30:23] = 8'(125 + $urandom_range(0, 4));
      5: v[30:23] = 8'(190 + $urandom_range(0, 64));
      6: v[30:23] = 8'(1 + $urandom_range(0, 60));
      7: v[22:0] = 23'h7FFFFF;
      default: ;
    endcase
    return v;
  endfunction

  // Scoreboard / protocol monitor, sampled on the falling edge.
  logic        prev_stall = 1'b0;
  logic [36:0] prev_snap = '0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready rule", in_ready, !out_valid || out_ready);
      if (prev_stall) chk("stall hold", {out_valid, dut_word()}, prev_snap);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected result", 1, 0);
        else chk("scoreboard", dut_word(), q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready)
        q.push_back(model({a_sign, a_exp, a_frac}, {b_sign, b_exp, b_frac}, rnd_mode));
      prev_stall = out_valid && !out_ready;
      prev_snap  = {out_valid, dut_word()};
    end
  end

  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic r, input logic [35:0] want);
    int  lat;
    logic got;
    drive(a, b, r);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    chk({nm, " timeout"}, got, 1);
    if (got) begin
      chk({nm, " latency"}, lat, 3);
      chk(nm, dut_word(), want);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (q.size() != 0 || out_valid); k++) @(posedge clk);
    #1;
    chk(nm, q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    logic [31:0] beats[5];

    // Model pins
    chk("model 1.5*2", model(32'h3FC00000, 32'h40000000, 0), {4'h0, 32'h40400000});
    chk("model tie rne", model(32'h3F800001, 32'h3FC00000, 0), {4'h1, 32'h3FC00002});
    chk("model tie rtz", model(32'h3F800001, 32'h3FC00000, 1), {4'h1, 32'h3FC00001});
    chk("model ovf rtz", model(32'h7F000000, 32'h40000000, 1), {4'h5, 32'h7F7FFFFF});

    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset outputs", dut_word(), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_one("1.5*2", 32'h3FC00000, 32'h40000000, 0, {4'h0, 32'h40400000});
    run_one("inf*0", 32'h7F800000, 32'h00000000, 0, {4'h8, 32'h7FC00000});
    run_one("nan*1", 32'h7FC00000, 32'h3F800000, 0, {4'h8, 32'h7FC00000});
    run_one("-inf*inf", 32'hFF800000, 32'h7F800000, 0, {4'h0, 32'hFF800000});
    run_one("tie rne", 32'h3F800001, 32'h3FC00000, 0, {4'h1, 32'h3FC00002});
    run_one("tie rtz", 32'h3F800001, 32'h3FC00000, 1, {4'h1, 32'h3FC00001});
    run_one("ovf rne", 32'h7F000000, 32'h40000000, 0, {4'h5, 32'h7F800000});
    run_one("ovf rtz", 32'h7F000000, 32'h40000000, 1, {4'h5, 32'h7F7FFFFF});
    run_one("underflow", 32'h00800000, 32'h3F000000, 0, {4'h3, 32'h00000000});
    run_one("carry out", 32'h3FFFFFFF, 32'h3F800001, 0, model(32'h3FFFFFFF, 32'h3F800001, 0));

    // Backpressure: five beats with the consumer stalled.
    for (int i = 0; i < 5; i++) beats[i] = {2'b00, 6'(i + 1), 24'(i * 7919)} + 32'h3E000000;
    base = n_out;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(beats[acc], 32'h40400000, 0);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("fill count", acc, 3);
    chk("stalled in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      drive(beats[acc], 32'h40400000, 0);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("all beats accepted", acc, 5);
    drain("backpressure drain");
    chk("backpressure results", n_out - base, 5);

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(beats[i], 32'h3FC00000, 0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre-reset valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async reset valid", out_valid, 0);
    chk("async reset outputs", dut_word(), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no stale output", out_valid, 0);
    end
    @(posedge clk); #1;
    run_one("after reset", 32'h3FC00000, 32'h40000000, 0, {4'h0, 32'h40400000});

    // Random traffic with random backpressure.
    for (int c = 0; c < 800; c++) begin
      drive(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain("final drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
